// File: rtl/linebuf_pkg.sv
// Shared definitions for the line-buffer window sequencer: FSM states,
// in_user bit positions and the default coordinate width.
package linebuf_pkg;

  localparam int LB_COORD_W  = 12;
  localparam int USER_HSTART = 0;
  localparam int USER_VSTART = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } lb_state_e;

endpackage

// File: rtl/tag_delay_pipe.sv
// Fixed-depth register pipe for window tags; reset clears every stage so no
// stale tag can leak out after a reset. DEPTH must be at least 1.
module tag_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/linebuf_window_ctrl.sv
// Column/row tracker and IDLE/FILL/RUN sequencer for a KxK line-buffer window;
// per-pixel tags are delayed SR_LATENCY cycles to line up with the line buffers.
module linebuf_window_ctrl
  import linebuf_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int SR_LATENCY  = 2,
  parameter int COORD_W     = LB_COORD_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_in_valid,
  input  logic [7:0]         i_in_user,
  input  logic [COORD_W-1:0] i_cfg_width,
  input  logic [COORD_W-1:0] i_cfg_height,
  output logic               o_win_valid,
  output logic [COORD_W-1:0] o_win_col,
  output logic [COORD_W-1:0] o_win_row,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_err_line_len,
  output logic               o_err_frame_short
);

  localparam logic [COORD_W-1:0] KM1   = COORD_W'(KERNEL_SIZE - 1);
  localparam logic [COORD_W-1:0] HALF  = COORD_W'(KERNEL_SIZE / 2);
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
  localparam logic [COORD_W:0]   C_INC = (COORD_W+1)'(1);
  localparam int                 TAG_W = 2*COORD_W + 3;

  lb_state_e          r_state;
  logic [COORD_W-1:0] r_col, r_row, r_width, r_height;
  logic               r_err_len, r_err_short;

  lb_state_e          w_state_nxt;
  logic [COORD_W-1:0] w_col_nxt, w_row_nxt, w_width_nxt, w_height_nxt;
  logic               w_err_len_nxt, w_err_short_nxt;
  logic               w_vs, w_hs, w_px, w_act, w_upd, w_to_run;
  logic [COORD_W:0]   w_col_inc;
  logic               w_win_valid, w_busy, w_frame_done;
  logic [COORD_W-1:0] w_win_col, w_win_row;
  logic [TAG_W-1:0]   w_tag_in, w_tag_out;

  // vstart dominates hstart; user bits only count on an accepted pixel
  assign w_vs      = i_in_valid & i_in_user[USER_VSTART];
  assign w_hs      = i_in_valid & i_in_user[USER_HSTART] & ~w_vs;
  assign w_px      = i_in_valid & ~w_vs & ~w_hs;
  assign w_act     = (r_state != IDLE);
  assign w_col_inc = {1'b0, r_col} + C_INC;

  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_width_nxt     = r_width;
    w_height_nxt    = r_height;
    w_err_len_nxt   = r_err_len;
    w_err_short_nxt = r_err_short;
    w_upd           = 1'b0;
    w_to_run        = 1'b0;
    w_frame_done    = 1'b0;

    if (w_vs) begin
      w_col_nxt       = '0;
      w_row_nxt       = '0;
      w_width_nxt     = i_cfg_width;
      w_height_nxt    = i_cfg_height;
      w_err_len_nxt   = 1'b0;
      w_err_short_nxt = w_act;
      w_state_nxt     = FILL;
      w_upd           = 1'b1;
    end else if (w_act && w_hs) begin
      if (r_col != r_width - C_ONE) w_err_len_nxt = 1'b1;
      w_col_nxt = '0;
      w_row_nxt = r_row + C_ONE;
      if (r_state == FILL && w_row_nxt == KM1) begin
        w_state_nxt = RUN;
        w_to_run    = 1'b1;
      end
      w_upd = 1'b1;
    end else if (w_act && w_px) begin
      // an overlong line holds col at the last column
      if (w_col_inc >= {1'b0, r_width}) begin
        w_err_len_nxt = 1'b1;
        w_col_nxt     = r_width - C_ONE;
      end else begin
        w_col_nxt = w_col_inc[COORD_W-1:0];
      end
      w_upd = 1'b1;
    end

    w_win_valid = w_upd && !w_vs && (r_state == RUN || w_to_run) && (w_col_nxt >= KM1);

    if (w_upd && w_row_nxt == w_height_nxt - C_ONE && w_col_nxt == w_width_nxt - C_ONE) begin
      w_frame_done = 1'b1;
      w_state_nxt  = IDLE;
    end

    w_busy = (w_state_nxt != IDLE);
  end

  assign w_win_col = w_win_valid ? (w_col_nxt - HALF) : '0;
  assign w_win_row = w_win_valid ? (w_row_nxt - HALF) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_err_len   <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_width     <= w_width_nxt;
      r_height    <= w_height_nxt;
      r_err_len   <= w_err_len_nxt;
      r_err_short <= w_err_short_nxt;
    end
  end

  assign w_tag_in = {w_win_valid, w_win_col, w_win_row, w_busy, w_frame_done};

  tag_delay_pipe #(
    .WIDTH (TAG_W),
    .DEPTH (SR_LATENCY)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (w_tag_in),
    .o_q     (w_tag_out)
  );

  assign {o_win_valid, o_win_col, o_win_row, o_busy, o_frame_done} = w_tag_out;
  assign o_err_line_len    = r_err_len;
  assign o_err_frame_short = r_err_short;

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Bench for linebuf_window_ctrl: directed frames plus randomized streams,
// checked every cycle against a pixel-level reference model.
module tb_linebuf_window_ctrl;
  import linebuf_pkg::*;

  localparam int K  = 3;
  localparam int L  = 2;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          i_reset, i_in_valid;
  logic [7:0]    i_in_user;
  logic [CW-1:0] i_cfg_width, i_cfg_height;
  logic          o_win_valid, o_busy, o_frame_done, o_err_line_len, o_err_frame_short;
  logic [CW-1:0] o_win_col, o_win_row;

  always #5 clk = ~clk;

  linebuf_window_ctrl #(.KERNEL_SIZE(K), .SR_LATENCY(L), .COORD_W(CW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .i_in_user(i_in_user),
    .i_cfg_width(i_cfg_width), .i_cfg_height(i_cfg_height),
    .o_win_valid(o_win_valid), .o_win_col(o_win_col), .o_win_row(o_win_row),
    .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_err_line_len(o_err_line_len), .o_err_frame_short(o_err_frame_short)
  );

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [CW-1:0] r;
    logic          busy;
    logic          fd;
  } tag_t;

  tag_t exp_q[$];
  int   m_mode, m_col, m_row, m_w, m_h;   // mode: 0 idle, 1 filling, 2 windows flowing
  bit   m_el, m_es;
  int   n_chk = 0, n_fail = 0;
  int   win_seen, fd_seen, first_c, first_r, last_c, last_r;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: one call per clock edge, from the stream rules in plain ints.
  task automatic model_step(bit rst, bit v, logic [7:0] u);
    tag_t t;
    bit   vs, hs, acc;
    t = '0;
    if (rst) begin
      m_mode = 0; m_col = 0; m_row = 0; m_w = 0; m_h = 0; m_el = 0; m_es = 0;
      exp_q.delete();
      return;
    end
    vs  = v && u[1];
    hs  = v && u[0] && !vs;
    acc = 0;
    if (vs) begin
      m_es = (m_mode != 0); m_el = 0;
      m_w = int'(i_cfg_width); m_h = int'(i_cfg_height);
      m_col = 0; m_row = 0; m_mode = 1; acc = 1;
    end else if (m_mode != 0 && hs) begin
      if (m_col != m_w - 1) m_el = 1;
      m_col = 0; m_row++;
      if (m_mode == 1 && m_row == K - 1) m_mode = 2;
      acc = 1;
    end else if (m_mode != 0 && v) begin
      if (m_col + 1 >= m_w) begin m_el = 1; m_col = m_w - 1; end
      else m_col++;
      acc = 1;
    end
    if (acc) begin
      if (m_mode == 2 && m_col >= K - 1) begin
        t.v = 1; t.c = CW'(m_col - K/2); t.r = CW'(m_row - K/2);
      end
      if (m_row == m_h - 1 && m_col == m_w - 1) begin t.fd = 1; m_mode = 0; end
    end
    t.busy = (m_mode != 0);
    exp_q.push_back(t);
    if (exp_q.size() > L) void'(exp_q.pop_front());
  endtask

  task automatic check_outputs();
    tag_t e;
    e = (exp_q.size() == L) ? exp_q[0] : '0;
    chk("win_valid", o_win_valid, e.v);
    if (e.v) begin
      chk("win_col", o_win_col, e.c);
      chk("win_row", o_win_row, e.r);
    end
    chk("busy", o_busy, e.busy);
    chk("frame_done", o_frame_done, e.fd);
    chk("err_line_len", o_err_line_len, m_el);
    chk("err_frame_short", o_err_frame_short, m_es);
    if (o_win_valid) begin
      if (win_seen == 0) begin first_c = o_win_col; first_r = o_win_row; end
      last_c = o_win_col; last_r = o_win_row;
      win_seen++;
    end
    if (o_frame_done) fd_seen++;
  endtask

  task automatic cyc(bit v, logic [7:0] u);
    i_in_valid = v; i_in_user = u;
    @(posedge clk);
    model_step(i_reset, v, u);
    #1;
    check_outputs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic clr();
    win_seen = 0; fd_seen = 0; first_c = -1; first_r = -1; last_c = -1; last_r = -1;
  endtask

  // gm: 0 back-to-back, 1 alternate idle, 2 random idles with stray user bits
  task automatic send_line(int n, logic [7:0] first_u, int gm);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, (i == 0) ? first_u : (8'($urandom) & 8'hFC));
      if (gm == 1) cyc(1'b0, 8'h00);
      if (gm == 2) begin
        int g;
        g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        for (int j = 0; j < g; j++) cyc(1'b0, 8'($urandom));
      end
    end
  endtask

  task automatic send_frame(int w, int h, int gm);
    i_cfg_width = CW'(w); i_cfg_height = CW'(h);
    for (int r = 0; r < h; r++) send_line(w, (r == 0) ? 8'h03 : 8'h01, gm);
  endtask

  task automatic chk_6x4(string tag);
    chk({tag, "_wins"}, win_seen, 8);
    chk({tag, "_first_c"}, first_c, 1);
    chk({tag, "_first_r"}, first_r, 1);
    chk({tag, "_last_c"}, last_c, 4);
    chk({tag, "_last_r"}, last_r, 2);
    chk({tag, "_fd"}, fd_seen, 1);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_in_valid = 1'b0; i_in_user = '0;
    i_cfg_width = 12'd6; i_cfg_height = 12'd4;
    clr();
    idle(2);
    i_reset = 1'b0;
    chk("rst_win_valid", o_win_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err_len", o_err_line_len, 0);

    // 6x4 continuous, then with alternating gaps
    clr(); send_frame(6, 4, 0); idle(L + 1); chk_6x4("cont");
    clr(); send_frame(6, 4, 1); idle(L + 1); chk_6x4("gap");

    // short line flagged at the next hstart
    i_cfg_width = 12'd6; i_cfg_height = 12'd4;
    send_line(6, 8'h03, 0);
    send_line(5, 8'h01, 0);
    chk("len_pre", o_err_line_len, 0);
    cyc(1'b1, 8'h01);
    chk("len_short", o_err_line_len, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00);
    send_line(6, 8'h01, 0);
    idle(3);
    // overlong line flagged on its 7th pixel, column held at 5
    send_line(6, 8'h03, 0);
    chk("len_clr", o_err_line_len, 0);
    send_line(6, 8'h01, 0);
    send_line(6, 8'h01, 0);
    chk("len_pre_ovf", o_err_line_len, 0);
    cyc(1'b1, 8'h00);
    chk("len_ovf", o_err_line_len, 1);
    cyc(1'b0, 8'h00);
    chk("ovf_wv", o_win_valid, 1);
    chk("ovf_col", o_win_col, 4);
    chk("ovf_row", o_win_row, 1);
    send_line(6, 8'h01, 0);
    idle(3);
    chk("len_sticky", o_err_line_len, 1);
    clr(); send_frame(6, 4, 0); idle(L + 1);
    chk("len_clr2", o_err_line_len, 0);
    chk_6x4("after_len");

    // vstart mid-frame at row 2 col 3
    i_cfg_width = 12'd6; i_cfg_height = 12'd4;
    send_line(6, 8'h03, 0); send_line(6, 8'h01, 0); send_line(4, 8'h01, 0);
    idle(3);
    chk("fs_pre", o_err_frame_short, 0);
    clr();
    cyc(1'b1, 8'h03);
    chk("fs_set", o_err_frame_short, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00);
    for (int r = 1; r < 4; r++) send_line(6, 8'h01, 0);
    idle(L + 1);
    chk_6x4("restart");
    chk("fs_sticky", o_err_frame_short, 1);

    // reset while windows are in flight
    send_line(6, 8'h03, 0); send_line(6, 8'h01, 0); send_line(4, 8'h01, 0);
    chk("pre_rst_wv", o_win_valid, 1);
    i_reset = 1'b1;
    cyc(1'b0, 8'h00);
    i_reset = 1'b0;
    chk("mrst_wv", o_win_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_col", o_win_col, 0);
    chk("mrst_fd", o_frame_done, 0);
    clr();
    send_line(6, 8'h01, 0); send_line(6, 8'h00, 0); idle(3);
    chk("mrst_ignored", win_seen, 0);
    chk("mrst_idle_busy", o_busy, 0);
    clr(); send_frame(6, 4, 0); idle(L + 1); chk_6x4("post_rst");

    // frame narrower than the kernel
    clr(); send_frame(2, 4, 0); idle(L + 1);
    chk("narrow_wins", win_seen, 0);
    chk("narrow_fd", fd_seen, 1);

    // randomized geometry, gaps, length errors and aborted frames
    for (int f = 0; f < 30; f++) begin
      int w, h, n;
      w = $urandom_range(1, 9); h = $urandom_range(1, 7);
      i_cfg_width = CW'(w); i_cfg_height = CW'(h);
      for (int r = 0; r < h; r++) begin
        n = w;
        if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) != 0) ? w + 1 : w - 1;
        if (n < 1) n = 1;
        send_line(n, (r == 0) ? 8'h03 : 8'h01, 2);
        if (r == 0) i_cfg_width = CW'($urandom_range(1, 9));
        if ($urandom_range(0, 15) == 0) break;
      end
      idle($urandom_range(0, 3));
    end
    idle(L + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
